// File: rtl/uart_pkg.sv
// ----------------------------------------------------------------------------
// uart_pkg
//   Definitions shared by the UART receive path: the default bit period, the
//   frame geometry (data width, start/stop bit levels) and the encoding of
//   the receiver FSM states.
// ----------------------------------------------------------------------------
package uart_pkg;

    localparam int   DEFAULT_BAUD_DIVISOR = 5;
    localparam int   DATA_BITS            = 8;
    localparam logic START_BIT            = 1'b0;
    localparam logic STOP_BIT             = 1'b1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } rx_state_t;

endpackage

// File: rtl/uart_receiver_if.sv
// ----------------------------------------------------------------------------
// uart_receiver_if
//   Bundles the receiver's line, byte-consumer and status signals.
//   master : the environment (drives the serial line and pops bytes)
//   slave  : the receiver (presents FIFO head, flags and status)
//
//   serial_in   : asynchronous serial line, idle high
//   rd_en       : pop the head byte (ignored while data_valid=0)
//   data_out    : FIFO head byte, first-word-fall-through
//   data_valid  : FIFO not empty
//   fifo_full   : FIFO holds its full depth
//   rx_busy     : receiver is inside a frame
//   frame_error : one-cycle pulse, stop bit sampled low
//   overrun     : one-cycle pulse, completed byte dropped on a full FIFO
// ----------------------------------------------------------------------------
interface uart_receiver_if;

    logic       serial_in;
    logic       rd_en;
    logic [7:0] data_out;
    logic       data_valid;
    logic       fifo_full;
    logic       rx_busy;
    logic       frame_error;
    logic       overrun;

    modport master (
        output serial_in, rd_en,
        input  data_out, data_valid, fifo_full, rx_busy, frame_error, overrun
    );

    modport slave (
        input  serial_in, rd_en,
        output data_out, data_valid, fifo_full, rx_busy, frame_error, overrun
    );

endinterface

// File: rtl/uart_rx_fifo.sv
// ----------------------------------------------------------------------------
// uart_rx_fifo
//   Byte FIFO behind the UART receiver. First-word-fall-through: o_data shows
//   the head entry whenever o_empty=0, and reads 0 while empty. A push and a
//   pop in the same cycle both take effect, even when full.
//
//   clk     : clock
//   rst     : synchronous, active-low reset (empties the FIFO)
//   i_push  : write i_data (dropped when full unless a pop happens too)
//   i_pop   : remove the head entry (ignored when empty)
//   i_data  : write data
//   o_data  : head entry
//   o_empty : no entries
//   o_full  : DEPTH entries
// ----------------------------------------------------------------------------
module uart_rx_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic [WIDTH-1:0] i_data,
    output logic [WIDTH-1:0] o_data,
    output logic             o_empty,
    output logic             o_full
);

    localparam int AW = $clog2(DEPTH);

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic             w_do_push;
    logic             w_do_pop;

    assign o_empty   = (r_wr_ptr == r_rd_ptr);
    assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                       (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_do_pop  = i_pop && !o_empty;
    // A pop in the same cycle frees the slot a full FIFO needs for the push.
    assign w_do_push = i_push && (!o_full || w_do_pop);

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of process evaluation order.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    // NOTE: the storage array is deliberately not reset; an entry is only
    // ever observed after it has been written, and o_data is forced to 0
    // while empty, so resetting it would add muxes for no behavioural gain.
    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= i_data;
    end

    assign o_data = o_empty ? '0 : r_mem[r_rd_ptr[AW-1:0]];

endmodule

// File: rtl/uart_receiver.sv
// ----------------------------------------------------------------------------
// uart_receiver
//   Receives 8N1 frames (start 0, 8 data bits LSB first, stop 1), each bit
//   BAUD_DIVISOR clocks long, and buffers completed bytes in uart_rx_fifo.
//   The line passes through a 2-flop synchroniser; the FSM samples each bit
//   near its middle and leaves at mid-stop so back-to-back frames work.
//
//   clk : clock
//   rst : synchronous, active-low reset
//   bus : uart_receiver_if.slave (serial line, byte pop, head byte, flags)
// ----------------------------------------------------------------------------
module uart_receiver
    import uart_pkg::*;
#(
    parameter int BAUD_DIVISOR = DEFAULT_BAUD_DIVISOR,
    parameter int FIFO_DEPTH   = 8
) (
    input  logic            clk,
    input  logic            rst,
    uart_receiver_if.slave  bus
);

    localparam int CW  = $clog2(BAUD_DIVISOR);
    localparam int BW  = $clog2(DATA_BITS);
    localparam int MID = BAUD_DIVISOR / 2;

    // The START state counts from 0 on the cycle after the falling edge was
    // seen, so the mid-start sample falls one count earlier than MID.
    localparam logic [CW-1:0] CNT_MID  = CW'(MID - 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(BAUD_DIVISOR - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BITS - 1);

    rx_state_t              r_state;
    rx_state_t              w_state_next;
    logic [1:0]             r_sync;
    logic [CW-1:0]          r_cnt;
    logic [BW-1:0]          r_bit_idx;
    logic [DATA_BITS-1:0]   r_shift;
    logic                   r_frame_error;
    logic                   r_overrun;

    logic                   w_rx_s;
    logic                   w_start_tick;
    logic                   w_bit_tick;
    logic                   w_push;
    logic                   w_frame_err;
    logic                   w_overrun;
    logic                   w_rx_busy;
    logic                   w_fifo_empty;
    logic                   w_fifo_full;

    // Two-flop synchroniser; resets to the idle-high line level.
    always_ff @(posedge clk) begin
        if (!rst) r_sync <= 2'b11;
        else      r_sync <= {r_sync[0], bus.serial_in};
    end

    assign w_rx_s       = r_sync[1];
    assign w_start_tick = (r_cnt == CNT_MID);
    assign w_bit_tick   = (r_cnt == CNT_LAST);

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!rst) r_state <= IDLE;
        else      r_state <= w_state_next;
    end

    // FSM next-state logic.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (w_rx_s == START_BIT) w_state_next = START;
            START:   if (w_start_tick) w_state_next = (w_rx_s == START_BIT) ? DATA : IDLE;
            DATA:    if (w_bit_tick && r_bit_idx == BIT_LAST) w_state_next = STOP;
            STOP:    if (w_bit_tick) w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    // FSM outputs.
    // NOTE: every signal written here gets a default first, so no path
    // through the case leaves one unassigned and no latch is inferred.
    always_comb begin
        w_rx_busy   = 1'b0;
        w_push      = 1'b0;
        w_frame_err = 1'b0;
        w_overrun   = 1'b0;
        case (r_state)
            START, DATA: w_rx_busy = 1'b1;
            STOP: begin
                w_rx_busy = 1'b1;
                if (w_bit_tick) begin
                    if (w_rx_s != STOP_BIT)              w_frame_err = 1'b1;
                    else if (!w_fifo_full || bus.rd_en)  w_push      = 1'b1;
                    else                                 w_overrun   = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Bit timing counter, data shift register and registered error pulses.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_cnt         <= '0;
            r_bit_idx     <= '0;
            r_shift       <= '0;
            r_frame_error <= 1'b0;
            r_overrun     <= 1'b0;
        end else begin
            r_frame_error <= w_frame_err;
            r_overrun     <= w_overrun;
            case (r_state)
                IDLE: r_cnt <= '0;
                START: begin
                    r_cnt     <= w_start_tick ? '0 : r_cnt + 1'b1;
                    r_bit_idx <= '0;
                end
                DATA: begin
                    if (w_bit_tick) begin
                        r_cnt     <= '0;
                        // LSB arrives first: insert at the top, shift right.
                        r_shift   <= {w_rx_s, r_shift[DATA_BITS-1:1]};
                        r_bit_idx <= r_bit_idx + 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                STOP: r_cnt <= w_bit_tick ? '0 : r_cnt + 1'b1;
                default: r_cnt <= '0;
            endcase
        end
    end

    uart_rx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (DATA_BITS)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_pop   (bus.rd_en),
        .i_data  (r_shift),
        .o_data  (bus.data_out),
        .o_empty (w_fifo_empty),
        .o_full  (w_fifo_full)
    );

    assign bus.data_valid  = !w_fifo_empty;
    assign bus.fifo_full   = w_fifo_full;
    assign bus.rx_busy     = w_rx_busy;
    assign bus.frame_error = r_frame_error;
    assign bus.overrun     = r_overrun;

endmodule

// File: tb/tb_uart_receiver.sv
// ----------------------------------------------------------------------------
// tb_uart_receiver
//   Scoreboard bench for uart_receiver. Stimulus pushes each byte it expects
//   to be delivered into sb_q; the monitor pops the FIFO (rd_en) and compares
//   data_out with the queue head, and measures flag pulse widths.
// ----------------------------------------------------------------------------
module tb_uart_receiver;

    localparam int BD    = 5;
    localparam int DEPTH = 8;

    logic clk = 1'b0;
    logic rst;

    uart_receiver_if bus ();

    uart_receiver #(
        .BAUD_DIVISOR (BD),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int         errors = 0;
    int         checks = 0;
    logic [7:0] sb_q [$];
    bit         consume_en = 1'b0;
    bit         pop_once   = 1'b0;
    int         fe_cnt = 0;
    int         ov_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: flag pulse widths, and scoreboard comparison of popped bytes.
    initial begin : monitor
        int fe_w;
        int ov_w;
        fe_w = 0;
        ov_w = 0;
        bus.rd_en = 1'b0;
        forever begin
            @(negedge clk);
            #1;
            if (bus.frame_error) fe_w++;
            else if (fe_w != 0) begin
                check("frame_error_width", fe_w, 1);
                fe_cnt++;
                fe_w = 0;
            end
            if (bus.overrun) ov_w++;
            else if (ov_w != 0) begin
                check("overrun_width", ov_w, 1);
                ov_cnt++;
                ov_w = 0;
            end
            if (bus.data_valid && (consume_en || pop_once)) begin
                if (sb_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_byte: got 0x%0h expected none", bus.data_out);
                end else begin
                    check("rx_byte", bus.data_out, sb_q.pop_front());
                end
                bus.rd_en = 1'b1;
                pop_once  = 1'b0;
            end else begin
                bus.rd_en = 1'b0;
            end
        end
    end

    // Drives one frame starting at the current negedge. With pop_at_stop the
    // monitor pops during the exact cycle the stop bit is sampled.
    task automatic send_frame(input logic [7:0] b, input logic stop_v, input bit pop_at_stop);
        logic [9:0] bits;
        bits = {stop_v, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            bus.serial_in = bits[i];
            if (i == 9 && pop_at_stop) begin
                repeat (BD - 1) @(negedge clk);
                pop_once = 1'b1;
                @(negedge clk);
            end else begin
                repeat (BD) @(negedge clk);
            end
        end
        bus.serial_in = 1'b1;
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while ((sb_q.size() != 0 || bus.data_valid) && n < 300) begin
            @(negedge clk);
            n++;
        end
        repeat (3) @(negedge clk);
        check(name, sb_q.size(), 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_data_out"},    bus.data_out,    0);
        check({tag, "_data_valid"},  bus.data_valid,  0);
        check({tag, "_fifo_full"},   bus.fifo_full,   0);
        check({tag, "_rx_busy"},     bus.rx_busy,     0);
        check({tag, "_frame_error"}, bus.frame_error, 0);
        check({tag, "_overrun"},     bus.overrun,     0);
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        int lat;
        int busy;
        int fe0;
        int ov0;

        bus.serial_in = 1'b1;
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b1;
        repeat (3) @(negedge clk);

        // 0xA5: latency from serial_in falling to data_valid, byte value.
        fe0 = fe_cnt;
        ov0 = ov_cnt;
        consume_en = 1'b1;
        sb_q.push_back(8'hA5);
        lat = 0;
        fork
            send_frame(8'hA5, 1'b1, 1'b0);
            begin
                for (int i = 1; i <= 60; i++) begin
                    @(negedge clk);
                    if (lat == 0 && bus.data_valid) lat = i;
                end
            end
        join
        check("a5_latency", lat, 50);
        wait_drain("a5_drain");
        check("a5_no_fe", fe_cnt, fe0);
        check("a5_no_ov", ov_cnt, ov0);

        // Back-to-back frames.
        sb_q.push_back(8'h00);
        sb_q.push_back(8'hFF);
        sb_q.push_back(8'h3C);
        send_frame(8'h00, 1'b1, 1'b0);
        send_frame(8'hFF, 1'b1, 1'b0);
        send_frame(8'h3C, 1'b1, 1'b0);
        wait_drain("b2b_drain");
        check("b2b_no_fe", fe_cnt, fe0);

        // Framing error, then recovery with a good frame.
        send_frame(8'h55, 1'b0, 1'b0);
        repeat (20) @(negedge clk);
        check("fe_count", fe_cnt, fe0 + 1);
        check("fe_no_data", bus.data_valid, 0);
        sb_q.push_back(8'h12);
        send_frame(8'h12, 1'b1, 1'b0);
        wait_drain("fe_recover_drain");

        // Two-cycle glitch while idle.
        fe0 = fe_cnt;
        ov0 = ov_cnt;
        busy = 0;
        bus.serial_in = 1'b0;
        repeat (2) @(negedge clk);
        bus.serial_in = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.rx_busy) busy++;
        end
        check("glitch_busy_seen", busy > 0, 1);
        check("glitch_busy_le3", busy <= 3, 1);
        check("glitch_no_data", bus.data_valid, 0);
        check("glitch_no_fe", fe_cnt, fe0);
        check("glitch_no_ov", ov_cnt, ov0);

        // Fill the FIFO, then overrun on the 9th frame.
        consume_en = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            sb_q.push_back(8'(i));
            send_frame(8'(i), 1'b1, 1'b0);
            check("fill_full", bus.fifo_full, (i == 8) ? 1 : 0);
        end
        check("fill_head", bus.data_out, 8'h01);
        send_frame(8'h09, 1'b1, 1'b0);
        repeat (5) @(negedge clk);
        check("ov_count", ov_cnt, ov0 + 1);
        check("ov_still_full", bus.fifo_full, 1);
        consume_en = 1'b1;
        wait_drain("ov_drain");

        // Same fill, but pop during the 9th stop sample: no overrun.
        consume_en = 1'b0;
        ov0 = ov_cnt;
        for (int i = 1; i <= 9; i++) sb_q.push_back(8'(i));
        for (int i = 1; i <= 8; i++) send_frame(8'(i), 1'b1, 1'b0);
        send_frame(8'h09, 1'b1, 1'b1);
        repeat (5) @(negedge clk);
        check("pushpop_no_ov", ov_cnt, ov0);
        check("pushpop_full", bus.fifo_full, 1);
        check("pushpop_head", bus.data_out, 8'h02);
        consume_en = 1'b1;
        wait_drain("pushpop_drain");

        // Reset during data bit 4, with a byte already buffered.
        consume_en = 1'b0;
        fe0 = fe_cnt;
        ov0 = ov_cnt;
        send_frame(8'h77, 1'b1, 1'b0);
        check("pre_rst_valid", bus.data_valid, 1);
        check("pre_rst_head", bus.data_out, 8'h77);
        fork
            send_frame(8'hF0, 1'b1, 1'b0);
            begin
                repeat (27) @(negedge clk);
                rst = 1'b0;
                @(negedge clk);
                check_reset_outputs("midrst");
                rst = 1'b1;
            end
        join
        repeat (10) @(negedge clk);
        check("midrst_idle_valid", bus.data_valid, 0);
        consume_en = 1'b1;
        sb_q.push_back(8'hC3);
        send_frame(8'hC3, 1'b1, 1'b0);
        wait_drain("midrst_c3_drain");
        check("midrst_no_fe", fe_cnt, fe0);
        check("midrst_no_ov", ov_cnt, ov0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
